// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// ALU/mux select codes, the FSM state enum and the per-state control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_e;

  // Moore part of the outputs; fetch/jump/branch are qualified outside
  // with mem_ready and zero, which arrive in the same cycle.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
    logic       branch;
    logic       jump;
    logic       fetch;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.fetch   = 1'b1;
      end
      DECODE:  c.alusrcb = SRCB_IMMSH;
      MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      MEMWR: begin
        c.mem_req  = 1'b1;
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTE: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_B;
        c.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      BEQEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_B;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PC_ALUOUT;
        c.branch  = 1'b1;
      end
      ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
      end
      ADDIWB:  c.regwrite = 1'b1;
      JEX: begin
        c.pcsrc = PC_JUMP;
        c.jump  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_control.sv
// ALU decoder: maps aluop and the R-type funct field onto the ALU operation.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB:   alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          F_ADD:   alucontrol_o = ALU_ADD;
          F_SUB:   alucontrol_o = ALU_SUB;
          F_AND:   alucontrol_o = ALU_AND;
          F_OR:    alucontrol_o = ALU_OR;
          F_SLT:   alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default:     alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath; stalls in FETCH, MEMRD
// and MEMWR until the shared memory reports mem_ready.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               iord,
  output logic               irwrite,
  output logic               memwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic               pcen,
  output logic [2:0]         alucontrol,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   rdy;
  logic   op_known;
  logic   pcwrite;

  assign rdy      = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
  assign op_known = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
                    (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = rdy ? MEMWB : MEMRD;
      MEMWR:   state_d = rdy ? FETCH : MEMWR;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // The control word is registered alongside the state so both always
  // describe the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      ctrl_q  <= ctrl_of(FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
    end
  end

  assign pcwrite    = (ctrl_q.fetch & rdy) | ctrl_q.jump;
  assign pcen       = pcwrite | (ctrl_q.branch & zero);
  assign irwrite    = ctrl_q.fetch & rdy;
  assign mem_req    = ctrl_q.mem_req;
  assign iord       = ctrl_q.iord;
  assign memwrite   = ctrl_q.memwrite;
  assign memtoreg   = ctrl_q.memtoreg;
  assign regdst     = ctrl_q.regdst;
  assign regwrite   = ctrl_q.regwrite;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign pcsrc      = ctrl_q.pcsrc;
  assign illegal_op = (state_q == DECODE) & ~op_known;
  assign state      = STATE_W'(state_q);

  alu_control u_alu_control (
    .aluop_i      (ctrl_q.aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized instruction-stream bench for multicycle_controller against a
// phase-list reference model with an expected-value queue.
module tb_multicycle_controller;
  import mips_pkg::*;

  localparam int W = 21;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       mem_req, iord, irwrite, memwrite, memtoreg, regdst, regwrite;
  logic       alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];

  multicycle_controller #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord), .irwrite(irwrite),
    .memwrite(memwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .pcen(pcen), .alucontrol(alucontrol), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] rtype_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs of one cycle, straight from the per-phase output list.
  function automatic logic [16:0] exp_ctrl(input state_e p, input logic [5:0] o,
                                           input logic [5:0] f, input logic z,
                                           input logic rdy);
    logic mr, io, irw, mw, m2r, rd, rw, sa, pe, ill;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    {mr, io, irw, mw, m2r, rd, rw, sa, pe, ill} = '0;
    sb = 2'b00; ps = 2'b00; alu = 3'b010;
    case (p)
      FETCH:   begin mr = 1; sb = 2'b01; irw = rdy; pe = rdy; end
      DECODE:  begin
        sb = 2'b11;
        ill = !(o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010});
      end
      MEMADR:  begin sa = 1; sb = 2'b10; end
      MEMRD:   begin mr = 1; io = 1; end
      MEMWB:   begin m2r = 1; rw = 1; end
      MEMWR:   begin mr = 1; io = 1; mw = 1; end
      EXECUTE: begin sa = 1; alu = rtype_alu(f); end
      ALUWB:   begin rd = 1; rw = 1; end
      BEQEX:   begin sa = 1; ps = 2'b01; alu = 3'b110; pe = z; end
      ADDIEX:  begin sa = 1; sb = 2'b10; end
      ADDIWB:  rw = 1;
      JEX:     begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {mr, io, irw, mw, m2r, rd, rw, sa, sb, ps, pe, alu, ill};
  endfunction

  // Builds the whole expected cycle stream for one instruction with the given
  // wait counts in FETCH and in the data-memory phase.
  task automatic model_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fw, input int mw);
    state_e ph[$];
    ph.push_back(FETCH);
    ph.push_back(DECODE);
    case (o)
      6'b100011: begin ph.push_back(MEMADR); ph.push_back(MEMRD); ph.push_back(MEMWB); end
      6'b101011: begin ph.push_back(MEMADR); ph.push_back(MEMWR); end
      6'b000000: begin ph.push_back(EXECUTE); ph.push_back(ALUWB); end
      6'b000100: ph.push_back(BEQEX);
      6'b001000: begin ph.push_back(ADDIEX); ph.push_back(ADDIWB); end
      6'b000010: ph.push_back(JEX);
      default: ;
    endcase
    foreach (ph[k]) begin
      int waits;
      logic r;
      waits = (ph[k] == FETCH) ? fw : ((ph[k] == MEMRD || ph[k] == MEMWR) ? mw : 0);
      for (int w = 0; w <= waits; w++) begin
        if (ph[k] == FETCH || ph[k] == MEMRD || ph[k] == MEMWR) r = (w == waits);
        else r = 1'($urandom_range(0, 1));
        rdy_q.push_back(r);
        exp_q.push_back({4'(ph[k]), exp_ctrl(ph[k], o, f, z, r)});
      end
    end
  endtask

  // Drives one instruction; reset_at >= 0 asserts reset in that cycle and
  // abandons the rest of the instruction.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fw, input int mw, input int reset_at);
    logic [W-1:0] e;
    logic r;
    model_instr(o, f, z, fw, mw);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      op = o; funct = f; zero = z; mem_ready = r;
      reset = (i == reset_at);
      @(negedge clk);
      check("state", 32'(state), 32'(e[W-1:17]));
      check("ctrl", 32'({mem_req, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
                         alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op}),
            32'(e[16:0]));
      @(posedge clk);
      #1;
      if (reset) begin
        reset = 1'b0;
        exp_q.delete();
        rdy_q.delete();
      end
    end
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] functs[5];
    logic [5:0] o, f;
    int reset_at;
    ops    = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    functs = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT};

    reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("reset_state", 32'(state), 32'(FETCH));
      check("reset_irwrite", 32'(irwrite), 32'(0));
      check("reset_regwrite", 32'(regwrite | memwrite), 32'(0));
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    run_instr(OP_LW,    6'h00, 1'b0, 0, 0, -1);
    run_instr(OP_RTYPE, F_SLT, 1'b0, 0, 0, -1);
    run_instr(OP_BEQ,   6'h00, 1'b1, 0, 0, -1);
    run_instr(OP_BEQ,   6'h00, 1'b0, 0, 0, -1);
    run_instr(OP_SW,    6'h00, 1'b0, 0, 3, -1);
    run_instr(6'b111111, 6'h00, 1'b0, 0, 0, -1);
    run_instr(OP_J,     6'h00, 1'b1, 0, 0, -1);
    run_instr(OP_LW,    6'h00, 1'b0, 3, 0, 1);  // reset inside a FETCH stall
    run_instr(OP_ADDI,  6'h00, 1'b0, 2, 0, -1);
    run_instr(OP_SW,    6'h00, 1'b0, 0, 4, 4);  // reset inside a MEMWR stall
    run_instr(OP_LW,    6'h00, 1'b1, 1, 2, -1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) o = 6'($urandom_range(0, 63));
      else o = ops[$urandom_range(0, 5)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : functs[$urandom_range(0, 4)];
      reset_at = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                $urandom_range(0, 3), reset_at);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Control unit for the multicycle MIPS datapath. A Moore FSM sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction, and produces all datapath enables and mux selects. A ready handshake stalls the FSM while the shared instruction/data memory is busy. It supports R-type (add, sub, and, or, slt), lw, sw, beq, addi and j.

Parameters:
MEM_HANDSHAKE, 1, 1 = wait on mem_ready in memory states; 0 = treat mem_ready as constantly 1
STATE_W, 4, width of the state register and of the state debug port

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  instruction[31:26], taken from the instruction register
funct  in  6  instruction[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory has completed the current access
mem_req  out  1  memory access in progress (FETCH, MEMRD, MEMWR)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
irwrite  out  1  instruction register load enable
memwrite  out  1  memory write enable
memtoreg  out  1  writeback data select: 1 = memory data
regdst  out  1  destination register select: 1 = rd
regwrite  out  1  register file write enable
alusrca  out  1  ALU A select: 0 = PC, 1 = register A
alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = immediate<<2
pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
pcen  out  1  PC load enable
alucontrol  out  3  ALU operation
illegal_op  out  1  unsupported opcode detected in DECODE
state  out  STATE_W  current state, for debug

Behaviour:
- State register updates on the rising edge of clk. When reset=1 at an edge, the next state is FETCH. Reset has priority over every transition, including one in the middle of a stalled memory access.
- Every output not listed for a state is 0 in that state. aluop is internal: 00 = add, 01 = sub, 10 = use funct.
- After reset the FSM is in FETCH. Outputs: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite=1 and pcwrite=1 only in the cycle where mem_ready=1, and the FSM then moves to DECODE. Otherwise it holds in FETCH.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by op:
  - lw (100011) or sw (101011) -> MEMADR
  - R-type (000000) -> EXECUTE
  - beq (000100) -> BEQEX
  - addi (001000) -> ADDIEX
  - j (000010) -> JEX
  - any other op -> illegal_op=1 for this cycle; next state FETCH; no register or memory write occurs.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next: FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1, all held stable for every stall cycle. Goes to FETCH in the cycle mem_ready=1.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next: ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next: FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1. Next: FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next: FETCH.
- JEX: pcsrc=10, pcwrite=1. Next: FETCH.
- pcen = pcwrite | (branch & zero). This is combinational and in the same cycle as its inputs.
- ALU decode (combinational from aluop and funct):
  - aluop 00 -> 010; aluop 01 -> 110
  - aluop 10, funct 100000 -> 010; 100010 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111
  - aluop 10 with any other funct -> 010
- Latency in cycles, with zero wait states: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3. Each wait cycle adds one in FETCH, MEMRD or MEMWR.
- With MEM_HANDSHAKE=0, there are no stalls and the mem_ready pin is ignored.
- The state encoding comes from the package enum. Any unreachable encoding goes to FETCH at the next edge.

Decomposition:
- Package mips_pkg holds:
  - the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - the funct constants
  - the aluop encodings
  - the state enum
  - the alusrcb and pcsrc select encodings
- Sub-module: the existing ALUControl ALU decoder, instantiated unchanged for the aluop/funct-to-alucontrol path. The FSM and output decode stay in this module.

Test Plan:
- reset=1 for 2 cycles, then op=100011 (lw) with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. MEMWB has regwrite=1, memtoreg=1, regdst=0.
- R-type with funct=101010 -> EXECUTE has alucontrol=111. ALUWB has regwrite=1, regdst=1. Total 4 cycles.
- beq with zero=1 in BEQEX -> pcen=1, pcsrc=01. Same instruction with zero=0 -> pcen=0.
- sw with mem_ready low for 3 cycles in MEMWR -> memwrite, iord and mem_req held at 1 for 4 cycles. Exit to FETCH on the ready cycle.
- op=111111 -> DECODE asserts illegal_op for one cycle, then FETCH. regwrite and memwrite are never asserted.
- reset asserted during a FETCH stall -> FETCH at the next edge with irwrite=0. Also: j -> JEX with pcsrc=10, pcen=1.
